// File: rtl/text_glyph_renderer.sv
// Text-mode pixel renderer: 80x30 cells of 8x16 pixels, 4-cycle pipeline with blinking underline cursor.
// Optional macro INVERSE_ATTR_EN: text_char[7] becomes an inverse-video attribute.
module text_glyph_renderer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_char,
  output logic [10:0] rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [7:0]  rom_dout,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic        pixel,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Constant multiply by COLS reduces to (row<<6)+(row<<4) for 80 columns.
  function automatic logic [11:0] cell_addr(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return 12'(row) * 12'(COLS) + 12'(col);
  endfunction

  logic [COL_W-1:0] col_p0;
  logic [ROW_W-1:0] row_p0;
  logic [3:0]       glyph_p0;
  logic [2:0]       bit_p0;
  logic             hit_p0;
  logic             vs_rise;

  logic [3:0]       glyph_p1, glyph_p2;
  logic [2:0]       bit_p1, bit_p2, bit_p3;
  logic             hit_p1, hit_p2, hit_p3;
  logic             vld_p1, vld_p2, vld_p3;
  logic             hs_p1, hs_p2, hs_p3;
  logic             vs_p1, vs_p2, vs_p3;
`ifdef INVERSE_ATTR_EN
  logic             inv_p3;
`endif

  logic             vs_q;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_on;
  logic             glyph_bit;
  logic             pixel_next;
  logic             unused;

  assign unused = &{1'b0, pix_y[9], text_char[7]};

  // Stage 0: cell decode and cursor hit from the raw timing-generator coordinates
  assign col_p0   = pix_x[COL_W+2:3];
  assign row_p0   = pix_y[ROW_W+3:4];
  assign glyph_p0 = pix_y[3:0];
  assign bit_p0   = pix_x[2:0];
  assign hit_p0   = cursor_en & blink_on & (col_p0 == cursor_col) & (row_p0 == cursor_row)
                    & (glyph_p0 >= 4'd14);
  assign vs_rise  = vs_in & ~vs_q;

  // Stage 2: glyph ROM address formed directly from the text RAM read data
  assign rom_ad  = {text_char[6:0], glyph_p2};
  assign rom_oce = 1'b1;

  // Stage 3: select the glyph bit, MSB is the leftmost pixel
`ifdef INVERSE_ATTR_EN
  assign glyph_bit = rom_dout[3'd7 - bit_p3] ^ inv_p3;
`else
  assign glyph_bit = rom_dout[3'd7 - bit_p3];
`endif
  assign pixel_next = vld_p3 & (glyph_bit ^ hit_p3);

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_ce    <= 1'b0;
      vs_q      <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      text_addr <= '0;
      glyph_p1  <= '0;
      bit_p1    <= '0;
      hit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
      glyph_p2  <= '0;
      bit_p2    <= '0;
      hit_p2    <= 1'b0;
      vld_p2    <= 1'b0;
      hs_p2     <= 1'b0;
      vs_p2     <= 1'b0;
      bit_p3    <= '0;
      hit_p3    <= 1'b0;
      vld_p3    <= 1'b0;
      hs_p3     <= 1'b0;
      vs_p3     <= 1'b0;
`ifdef INVERSE_ATTR_EN
      inv_p3    <= 1'b0;
`endif
      pixel     <= 1'b0;
      de_out    <= 1'b0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
    end else begin
      rom_ce <= 1'b1;
      vs_q   <= vs_in;
      if (vs_rise) begin
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // Stage 1: text RAM address; blanked cells read address 0
      text_addr <= de_in ? cell_addr(row_p0, col_p0) : 12'd0;
      glyph_p1  <= glyph_p0;
      bit_p1    <= bit_p0;
      hit_p1    <= hit_p0;
      vld_p1    <= de_in;
      hs_p1     <= hs_in;
      vs_p1     <= vs_in;

      glyph_p2  <= glyph_p1;
      bit_p2    <= bit_p1;
      hit_p2    <= hit_p1;
      vld_p2    <= vld_p1;
      hs_p2     <= hs_p1;
      vs_p2     <= vs_p1;

      bit_p3    <= bit_p2;
      hit_p3    <= hit_p2;
      vld_p3    <= vld_p2;
      hs_p3     <= hs_p2;
      vs_p3     <= vs_p2;
`ifdef INVERSE_ATTR_EN
      inv_p3    <= text_char[7];
`endif

      // Stage 4: registered video outputs
      pixel     <= pixel_next;
      de_out    <= vld_p3;
      hs_out    <= hs_p3;
      vs_out    <= vs_p3;
    end
  end

endmodule

// File: tb/tb_text_glyph_renderer.sv
// Directed bench for text_glyph_renderer with 1-cycle text RAM and glyph ROM models.
module tb_text_glyph_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic        de_in, hs_in, vs_in;
  logic [11:0] text_addr;
  logic [7:0]  text_char;
  logic [10:0] rom_ad;
  logic        rom_ce, rom_oce;
  logic [7:0]  rom_dout;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        pixel, de_out, hs_out, vs_out;

  logic [7:0] ram [0:4095];
  logic [7:0] rom [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    text_char <= ram[text_addr];
    rom_dout  <= rom[rom_ad];
  end

  text_glyph_renderer dut (
    .clk(clk), .reset(reset),
    .pix_x(pix_x), .pix_y(pix_y),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .text_addr(text_addr), .text_char(text_char),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .pixel(pixel), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  // Apply one input sample, then return 1 time unit after the edge that captured it.
  task automatic drive(input int x, input int y, input logic de, input logic hs, input logic vs);
    pix_x = 10'(x);
    pix_y = 10'(y);
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(123, 77, 1, 1, 1);
    drive(300, 200, 1, 0, 0);
    drive(45, 310, 1, 1, 1);
    n_cmp++;
    if (rom_ce !== 1'b0) begin n_err++; $display("FAIL reset_rom_ce: got %0b want 0", rom_ce); end
    n_cmp++;
    if ({pixel, de_out, hs_out, vs_out} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0000", {pixel, de_out, hs_out, vs_out});
    end
    n_cmp++;
    if (text_addr !== 12'd0) begin n_err++; $display("FAIL reset_text_addr: got %0d want 0", text_addr); end
    n_cmp++;
    if (rom_oce !== 1'b1) begin n_err++; $display("FAIL rom_oce: got %0b want 1", rom_oce); end
    reset = 1'b0;
    drive(0, 0, 1, 0, 0);
    n_cmp++;
    if (rom_ce !== 1'b1) begin n_err++; $display("FAIL release_rom_ce: got %0b want 1", rom_ce); end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (de_out !== 1'b0) begin n_err++; $display("FAIL release_de_early: got %0b want 0", de_out); end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (de_out !== 1'b1) begin n_err++; $display("FAIL release_de_first: got %0b want 1", de_out); end
  endtask

  task automatic test_char;
    logic [7:0] bytes [3];
    int         x0 [3];
    int         y0 [3];
    int         j;
    logic       e;
    bytes = '{8'h18, 8'hA5, 8'hF0};
    x0    = '{0, 8, 0};
    y0    = '{0, 0, 5};
    for (int i = 0; i < 27; i++) begin
      if (i < 24) drive(x0[i/8] + i % 8, y0[i/8], 1, 0, 0);
      else        drive(0, 0, 0, 0, 0);
      if (i == 0) begin
        n_cmp++;
        if (text_addr !== 12'd0) begin n_err++; $display("FAIL char_text_addr0: got %0d want 0", text_addr); end
      end
      if (i == 1) begin
        n_cmp++;
        if (rom_ad !== 11'h410) begin n_err++; $display("FAIL char_rom_ad: got %h want 410", rom_ad); end
      end
      if (i == 8) begin
        n_cmp++;
        if (text_addr !== 12'd1) begin n_err++; $display("FAIL char_text_addr1: got %0d want 1", text_addr); end
      end
      if (i >= 3) begin
        j = i - 3;
        e = bytes[j/8][7 - j % 8];
        n_cmp++;
        if ({de_out, pixel} !== {1'b1, e}) begin
          n_err++; $display("FAIL char_pixel[%0d]: got de=%0b pix=%0b want de=1 pix=%0b", j, de_out, pixel, e);
        end
      end
    end
  endtask

  task automatic test_corner;
    drive(639, 479, 1, 0, 0);
    n_cmp++;
    if (text_addr !== 12'd2399) begin n_err++; $display("FAIL corner_text_addr: got %0d want 2399", text_addr); end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (rom_ad !== 11'h5AF) begin n_err++; $display("FAIL corner_rom_ad: got %h want 5af", rom_ad); end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({de_out, pixel} !== 2'b11) begin n_err++; $display("FAIL corner_pixel: got %b want 11", {de_out, pixel}); end
    drive(639, 479, 0, 1, 1);
    n_cmp++;
    if (text_addr !== 12'd0) begin n_err++; $display("FAIL blank_text_addr: got %0d want 0", text_addr); end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({hs_out, vs_out} !== 2'b00) begin n_err++; $display("FAIL sync_early: got %b want 00", {hs_out, vs_out}); end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if ({hs_out, vs_out, de_out, pixel} !== 4'b1100) begin
      n_err++; $display("FAIL blank_sync: got %b want 1100", {hs_out, vs_out, de_out, pixel});
    end
  endtask

  task automatic test_cursor;
    int   xs [26];
    int   ys [26];
    logic ex [26];
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    for (int k = 0; k < 9; k++) begin
      xs[k] = 40 + k;      ys[k] = 46;      ex[k] = (k < 8);
      xs[k + 9] = 40 + k;  ys[k + 9] = 47;  ex[k + 9] = (k < 8);
    end
    for (int k = 0; k < 8; k++) begin
      xs[k + 18] = 40 + k; ys[k + 18] = 45; ex[k + 18] = 1'b0;
    end
    for (int i = 0; i < 29; i++) begin
      if (i < 26) drive(xs[i], ys[i], 1, 0, 0);
      else        drive(0, 0, 0, 0, 0);
      if (i >= 3) begin
        n_cmp++;
        if (pixel !== ex[i - 3]) begin
          n_err++;
          $display("FAIL cursor_pixel(%0d,%0d): got %0b want %0b", xs[i - 3], ys[i - 3], pixel, ex[i - 3]);
        end
      end
    end
    cursor_en = 1'b0;
    drive(40, 46, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (pixel !== 1'b0) begin n_err++; $display("FAIL cursor_disabled: got %0b want 0", pixel); end
  endtask

  task automatic test_blink;
    logic want [3];
    int   pulses [3];
    want   = '{1'b1, 1'b0, 1'b1};
    pulses = '{29, 1, 30};
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    for (int p = 0; p < 10; p++) begin
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 1);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < pulses[s]; p++) begin
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
      end
      drive(40, 46, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      n_cmp++;
      if (pixel !== want[s]) begin n_err++; $display("FAIL blink_step%0d: got %0b want %0b", s, pixel, want[s]); end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_inverse;
    logic [7:0] first;
    logic       e;
`ifdef INVERSE_ATTR_EN
    first = 8'hE7;
`else
    first = 8'h18;
`endif
    for (int i = 0; i < 19; i++) begin
      if (i < 16) drive(i, 16, 1, 0, 0);
      else        drive(0, 0, 0, 0, 0);
      if (i >= 3) begin
        e = (i - 3 < 8) ? first[7 - (i - 3)] : 8'h18 >> (7 - (i - 11)) & 1'b1;
        n_cmp++;
        if (pixel !== e) begin n_err++; $display("FAIL attr_pixel[%0d]: got %0b want %0b", i - 3, pixel, e); end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    pix_x      = '0;
    pix_y      = '0;
    de_in      = 1'b0;
    hs_in      = 1'b0;
    vs_in      = 1'b0;
    cursor_en  = 1'b0;
    cursor_col = '0;
    cursor_row = '0;
    text_char  = '0;
    rom_dout   = '0;
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    for (int a = 0; a < 2048; a++) rom[a] = 8'h00;
    ram[0]    = 8'h41;
    ram[1]    = 8'h7E;
    ram[80]   = 8'hC1;
    ram[81]   = 8'h41;
    ram[2399] = 8'h5A;
    rom[11'h410] = 8'h18;
    rom[11'h415] = 8'hF0;
    rom[11'h7E0] = 8'hA5;
    rom[11'h5AF] = 8'h01;
    rom[11'h41F] = 8'hFF;

    test_reset;
    test_char;
    test_corner;
    test_cursor;
    test_blink;
    test_inverse;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
